// File: rtl/gen_audio_mixer.sv
// rtl/gen_audio_mixer.sv - multi-voice programmable tone generator and saturating mixer
module gen_audio_mixer #(
    parameter int CHANNELS     = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int PHASE_WIDTH  = 24,
    parameter int VOL_WIDTH    = 4
) (
    input  logic                          I_clk,
    input  logic                          I_reset,
    input  logic                          I_sample_req,
    input  logic                          I_cfg_we,
    input  logic [$clog2(CHANNELS)-1:0]   I_cfg_ch,
    input  logic [PHASE_WIDTH-1:0]        I_cfg_freq,
    input  logic [1:0]                    I_cfg_wave,
    input  logic [VOL_WIDTH-1:0]          I_cfg_vol,
    input  logic                          I_cfg_en,
    output logic [SAMPLE_WIDTH-1:0]       O_sample,
    output logic                          O_sample_valid,
    output logic                          O_busy
);

    localparam int SW = SAMPLE_WIDTH;
    localparam int PW = PHASE_WIDTH;
    localparam int VW = VOL_WIDTH;
    localparam int CW = $clog2(CHANNELS);
    // Worst case sum of CHANNELS full-scale voices fits with one spare bit
    localparam int AW = SW + CW + 1;

    localparam logic [CW-1:0]        LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [SW-1:0]        MSB_MASK = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-SW+1){1'b1}}, {(SW-1){1'b0}}};
    localparam logic [15:0]          LFSR_SEED = 16'hACE1;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Per-voice configuration and phase
    logic [PW-1:0] voice_freq  [CHANNELS];
    logic [1:0]    voice_wave  [CHANNELS];
    logic [VW-1:0] voice_vol   [CHANNELS];
    logic          voice_en    [CHANNELS];
    logic [PW-1:0] voice_phase [CHANNELS];

    logic [CW-1:0]        ch;
    logic signed [AW-1:0] acc;
    logic [15:0]          lfsr;
    logic [15:0]          lfsr_next;

    logic                    accept;
    logic                    scan_last;
    logic [SW-1:0]           p;
    logic [SW-1:0]           wave_val;
    logic signed [AW+VW-1:0] prod;
    logic signed [AW-1:0]    contrib;
    logic signed [AW-1:0]    acc_sum;

    // Clip the wide accumulator into the signed output range
    function automatic logic [SW-1:0] saturate(input logic signed [AW-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(SW-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(SW-1){1'b0}}};
        end else begin
            return v[SW-1:0];
        end
    endfunction

    assign accept    = (state == S_IDLE) && I_sample_req;
    assign scan_last = (state == S_SCAN) && (ch == LAST_CH);
    assign O_busy    = (state != S_IDLE);

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // State register
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: requests only start a scan from IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (I_sample_req) state_next = S_SCAN;
            S_SCAN:  if (ch == LAST_CH) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Waveform, volume scaling and running sum for the voice being scanned
    always_comb begin
        p = voice_phase[ch][PW-1 -: SW];
        case (voice_wave[ch])
            WAVE_SQUARE: wave_val = p[SW-1] ? MSB_MASK : ~MSB_MASK;
            WAVE_SAW:    wave_val = p ^ MSB_MASK;
            WAVE_TRI:    wave_val = {(p[SW-1] ? ~p[SW-2:0] : p[SW-2:0]), 1'b0} ^ MSB_MASK;
            default:     wave_val = SW'({lfsr, {SW{1'b0}}} >> 16);
        endcase
        prod    = $signed({{(AW+VW-SW){wave_val[SW-1]}}, wave_val})
                * $signed({{AW{1'b0}}, voice_vol[ch]});
        contrib = voice_en[ch] ? AW'(prod >>> VW) : '0;
        acc_sum = acc + contrib;
    end

    // Scan bookkeeping: voice index, accumulator and noise source
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            ch   <= '0;
            acc  <= '0;
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            ch   <= '0;
            acc  <= '0;
            lfsr <= lfsr_next;
        end else if (state == S_SCAN) begin
            ch  <= ch + CW'(1);
            acc <= acc_sum;
        end
    end

    // Output sample register; the final voice's sum is clipped on the way in
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            O_sample       <= '0;
            O_sample_valid <= 1'b0;
        end else begin
            O_sample_valid <= scan_last;
            if (scan_last) begin
                O_sample <= saturate(acc_sum);
            end
        end
    end

    // Voice configuration writes
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                voice_freq[i] <= '0;
                voice_wave[i] <= '0;
                voice_vol[i]  <= '0;
                voice_en[i]   <= 1'b0;
            end
        end else if (I_cfg_we) begin
            voice_freq[I_cfg_ch] <= I_cfg_freq;
            voice_wave[I_cfg_ch] <= I_cfg_wave;
            voice_vol[I_cfg_ch]  <= I_cfg_vol;
            voice_en[I_cfg_ch]   <= I_cfg_en;
        end
    end

    // Phase accumulators; a disabling write overrides a same-cycle advance
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                voice_phase[i] <= '0;
            end
        end else begin
            if ((state == S_SCAN) && voice_en[ch]) begin
                voice_phase[ch] <= voice_phase[ch] + voice_freq[ch];
            end
            if (I_cfg_we && !I_cfg_en) begin
                voice_phase[I_cfg_ch] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gen_audio_mixer.sv
// tb/tb_gen_audio_mixer.sv - self-checking bench for gen_audio_mixer
module tb_gen_audio_mixer;

    localparam int CH = 4;

    logic        I_clk;
    logic        I_reset;
    logic        I_sample_req;
    logic        I_cfg_we;
    logic [1:0]  I_cfg_ch;
    logic [23:0] I_cfg_freq;
    logic [1:0]  I_cfg_wave;
    logic [3:0]  I_cfg_vol;
    logic        I_cfg_en;
    logic [15:0] O_sample;
    logic        O_sample_valid;
    logic        O_busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned freq_m  [CH];
    int unsigned phase_m [CH];
    int          wave_m  [CH];
    int          vol_m   [CH];
    bit          en_m    [CH];
    int          lfsr_m;

    gen_audio_mixer #(
        .CHANNELS(4), .SAMPLE_WIDTH(16), .PHASE_WIDTH(24), .VOL_WIDTH(4)
    ) dut (
        .I_clk(I_clk),
        .I_reset(I_reset),
        .I_sample_req(I_sample_req),
        .I_cfg_we(I_cfg_we),
        .I_cfg_ch(I_cfg_ch),
        .I_cfg_freq(I_cfg_freq),
        .I_cfg_wave(I_cfg_wave),
        .I_cfg_vol(I_cfg_vol),
        .I_cfg_en(I_cfg_en),
        .O_sample(O_sample),
        .O_sample_valid(O_sample_valid),
        .O_busy(O_busy)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            freq_m[i] = 0; phase_m[i] = 0; wave_m[i] = 0; vol_m[i] = 0; en_m[i] = 0;
        end
        lfsr_m = 'hACE1;
    endtask

    // One output sample computed from the current model state with integer arithmetic
    function automatic int model_sample();
        int acc = 0;
        for (int i = 0; i < CH; i++) begin
            if (en_m[i]) begin
                int p = int'(phase_m[i] >> 8);
                int w;
                int fold;
                case (wave_m[i])
                    0: w = (p < 32768) ? 32767 : -32768;
                    1: w = p - 32768;
                    2: begin
                        fold = (p < 32768) ? p : 65535 - p;
                        w = 2 * fold - 32768;
                    end
                    default: w = (lfsr_m >= 32768) ? lfsr_m - 65536 : lfsr_m;
                endcase
                acc += (w * vol_m[i]) >>> 4;
            end
        end
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic cfg(input int ch, input int unsigned freq, input int wave, input int vol, input bit en);
        I_cfg_we   = 1'b1;
        I_cfg_ch   = 2'(ch);
        I_cfg_freq = 24'(freq);
        I_cfg_wave = 2'(wave);
        I_cfg_vol  = 4'(vol);
        I_cfg_en   = en;
        @(posedge I_clk); #1;
        I_cfg_we   = 1'b0;
        freq_m[ch] = freq & 32'hFFFFFF;
        wave_m[ch] = wave;
        vol_m[ch]  = vol;
        en_m[ch]   = en;
        if (!en) phase_m[ch] = 0;
    endtask

    // Issue one request (optionally a second one while busy) and check latency, busy and value
    task automatic do_request(input string tag, input bit extra, output logic signed [31:0] got);
        int exp_s;
        int b;
        int pulses = 0;
        int vcycle = -1;
        int busy_ok = 1;
        lfsr_m = ((lfsr_m << 1) | (((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1)) & 'hFFFF;
        exp_s = model_sample();
        for (int i = 0; i < CH; i++)
            if (en_m[i]) phase_m[i] = (phase_m[i] + freq_m[i]) & 32'hFFFFFF;
        got = 'x;
        I_sample_req = 1'b1;
        @(posedge I_clk); #1;
        for (int c = 1; c <= 12; c++) begin
            b = (c <= CH + 1) ? 1 : 0;
            if (O_busy !== 1'(b)) busy_ok = 0;
            if (O_sample_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    vcycle = c;
                    got = $signed(O_sample);
                end
            end
            I_sample_req = (extra && c == 2) ? 1'b1 : 1'b0;
            @(posedge I_clk); #1;
        end
        I_sample_req = 1'b0;
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_latency"}, vcycle, CH + 1);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_sample"}, got, exp_s);
        check({tag, "_hold"}, $signed(O_sample), exp_s);
    endtask

    initial begin
        logic signed [31:0] got;
        int pulses;
        I_reset = 1'b1; I_sample_req = 1'b0; I_cfg_we = 1'b0; I_cfg_ch = '0;
        I_cfg_freq = '0; I_cfg_wave = '0; I_cfg_vol = '0; I_cfg_en = 1'b0;
        model_reset();
        repeat (2) @(posedge I_clk);
        #1;
        check("reset_sample", $signed(O_sample), 0);
        check("reset_valid", O_sample_valid, 0);
        check("reset_busy", O_busy, 0);
        I_reset = 1'b0;
        @(posedge I_clk); #1;

        // Saw on voice 0
        cfg(0, 'h100000, 1, 15, 1);
        do_request("saw1", 0, got); check("saw1_const", got, -30720);
        do_request("saw2", 0, got); check("saw2_const", got, -26880);
        do_request("saw3", 0, got); check("saw3_const", got, -23040);

        // Disable then re-enable restarts phase
        cfg(0, 'h100000, 1, 15, 0);
        do_request("dis", 0, got); check("dis_const", got, 0);
        cfg(0, 'h100000, 1, 15, 1);
        do_request("reen", 0, got); check("reen_const", got, -30720);

        // Second request while busy is ignored
        do_request("busyign", 1, got);

        // Four full-scale squares clip both ways
        for (int i = 0; i < CH; i++) cfg(i, 0, 0, 0, 0);
        for (int i = 0; i < CH; i++) cfg(i, 'h800000, 0, 15, 1);
        do_request("sat1", 0, got); check("sat1_const", got, 32767);
        do_request("sat2", 0, got); check("sat2_const", got, -32768);

        // Reset in the middle of a scan
        I_sample_req = 1'b1;
        @(posedge I_clk); #1;
        I_sample_req = 1'b0;
        @(posedge I_clk); #1;
        I_reset = 1'b1;
        #1;
        check("midreset_sample", $signed(O_sample), 0);
        check("midreset_valid", O_sample_valid, 0);
        check("midreset_busy", O_busy, 0);
        model_reset();
        @(posedge I_clk); #1;
        I_reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (O_sample_valid !== 1'b0) pulses++;
            @(posedge I_clk); #1;
        end
        check("midreset_nopulse", pulses, 0);

        // Noise voice alone, first sample after reset
        cfg(2, 0, 3, 15, 1);
        do_request("noise", 0, got); check("noise_const", got, 21542);

        // Triangle voice alone
        cfg(2, 0, 3, 15, 0);
        cfg(1, 'h400000, 2, 15, 1);
        for (int k = 0; k < 4; k++) do_request($sformatf("tri%0d", k), 0, got);

        // Randomised configuration and requests
        for (int n = 0; n < 40; n++) begin
            int nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                cfg($urandom_range(0, CH - 1), $urandom & 32'hFFFFFF, $urandom_range(0, 3),
                    $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
            do_request($sformatf("rnd%0d", n), 0, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
